vx_warp_scheduler: RTL and testbench
====================================

# vx_warp_scheduler

Per-cycle warp selector for the fetch stage. Tracks which warps are active and which are stalled on an unresolved branch, and grants one eligible warp per cycle in round-robin order. The fetch stage uses the granted warp number to choose which warp's PC/thread-mask to present to the I-cache. Spawn and terminate events from the execute/writeback path grow and shrink the active set.

## Interface
- NUM_WARPS, 4: number of hardware warps, power of two, 2..32
- WARP_W, $clog2(NUM_WARPS): derived localparam, not overridable
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- global_stall  in  1  pipeline freeze; no grant this cycle
- spawn_valid  in  1  activate warps in spawn_mask
- spawn_mask  in  NUM_WARPS  warps to activate; ORed into active set
- term_valid  in  1  deactivate term_warp (ebreak)
- term_warp  in  WARP_W  warp being terminated
- br_issue_valid  in  1  decode saw a branch/jal; stall br_issue_warp
- br_issue_warp  in  WARP_W  warp issuing the branch
- br_resolve_valid  in  1  execute resolved a branch; release br_resolve_warp
- br_resolve_warp  in  WARP_W  warp whose branch resolved
- sched_valid  out  1  a warp is granted this cycle
- sched_warp  out  WARP_W  granted warp; 0 when sched_valid=0
- active_mask  out  NUM_WARPS  registered active set
- all_done  out  1  active_mask == 0

## Operation
- State: active[NUM_WARPS], stalled[NUM_WARPS], last_grant[WARP_W].
- Reset values: active = 1 (only warp 0), stalled = 0, last_grant = NUM_WARPS-1. Outputs after reset: sched_valid=1, sched_warp=0 (unless global_stall), active_mask=1, all_done=0.
- eligible = active & ~stalled (& ~blocked when barrier enabled).
- Grant: if global_stall or eligible==0, sched_valid=0, sched_warp=0, last_grant holds. Otherwise grant the first eligible warp scanning last_grant+1, last_grant+2, ... modulo NUM_WARPS (wraps NUM_WARPS-1 -> 0); last_grant <= granted warp.
- A single eligible warp is granted every cycle (no forced idle cycles).
- Spawn: active <= active | spawn_mask. Spawning an already-active warp has no effect.
- Terminate: active[term_warp] <= 0, stalled[term_warp] <= 0.
- Same cycle spawn and terminate of the same warp: terminate wins.
- Branch issue: stalled[w] <= 1; ignored if warp inactive. Branch resolve: stalled[w] <= 0; resolve of a non-stalled warp is ignored.
- Same cycle issue and resolve of the same warp: issue wins (stalled stays 1). Different warps: both apply.
- At most one branch outstanding per warp; upstream guarantees this.
- all_done is combinational from active; once 0 it stays 0 until spawn or reset.

## Timing
- Grant outputs are combinational from registered state; zero-cycle latency from state to grant.
- All event inputs take effect on the next rising edge; a warp stalled by br_issue at edge N is not granted in cycle N+1 onward; a warp released at edge N is eligible in cycle N+1.
- Reset asserted mid-operation returns all state to reset values asynchronously; outstanding stalls and spawned warps are discarded.

## Configuration
- VX_SCHED_BARRIER_EN defined: adds ports bar_valid in 1, bar_warp in WARP_W, bar_count in WARP_W+1, plus state blocked[NUM_WARPS] and arrive counter (WARP_W+1 bits, reset 0). On bar_valid: if arrive+1 == bar_count, clear all blocked bits and arrive (arriving warp never blocks); else blocked[bar_warp] <= 1, arrive <= arrive+1. Terminating a blocked warp clears its blocked bit; arrive is unchanged.
- Undefined: barrier ports and state absent; eligible excludes the blocked term.

## Structure
- Shared package vx_sched_pkg: NUM_WARPS default, WARP_W function, warp-mask typedef.
- One sub-module vx_rr_picker: parameterised NUM_WARPS round-robin priority picker (request mask + last pointer -> valid, index); combinational, reused by later arbiters.

## Test plan
- Reset, no events, NUM_WARPS=4 -> sched_warp=0 every cycle, sched_valid=1, active_mask=4'b0001.
- spawn_mask=4'b1110 at edge 1 -> grants 1,2,3,0,1,... starting in cycle 2 (last_grant was 0).
- With all 4 active, br_issue warp 2 -> sequence skips 2; br_resolve warp 2 three cycles later -> 2 granted on its next turn.
- Same-cycle br_issue and br_resolve on warp 1 -> warp 1 remains stalled; spawn and term on warp 3 -> active_mask[3]=0.
- Terminate warps 1,2,3 then 0 -> all_done=1, sched_valid=0, sched_warp=0; global_stall asserted mid-sequence holds last_grant.
- With VX_SCHED_BARRIER_EN, bar_count=3: warps 0,1 arrive -> blocked=4'b0011, only 2,3 granted; warp 2 arrives -> blocked clears next cycle, arrive=0.

Source files
------------

// File: rtl/vx_sched_pkg.sv
// vx_sched_pkg: shared warp-scheduler defaults, width helper and warp-mask type.
package vx_sched_pkg;
    localparam int NUM_WARPS_DEF = 4;
    function automatic int warp_w(input int n);
        return $clog2(n);
    endfunction
    typedef logic [NUM_WARPS_DEF-1:0] warp_mask_t;
endpackage

// File: rtl/vx_rr_picker.sv
// vx_rr_picker: combinational round-robin picker, scans last+1, last+2, ... modulo N.
module vx_rr_picker
    import vx_sched_pkg::*;
#(
    parameter int N = NUM_WARPS_DEF
) (
    input  logic [N-1:0]          req_i,
    input  logic [warp_w(N)-1:0]  last_i,
    output logic                  valid_o,
    output logic [warp_w(N)-1:0]  idx_o
);
    localparam int W = warp_w(N);
    logic [W-1:0] cand;
    logic         found;
    always_comb begin
        valid_o = |req_i;
        idx_o   = '0;
        cand    = '0;
        found   = 1'b0;
        // N is a power of two, so W-bit addition wraps N-1 -> 0 for free
        for (int i = 1; i <= N; i++) begin
            cand = last_i + W'(i);
            if (!found && req_i[cand]) begin
                found = 1'b1;
                idx_o = cand;
            end
        end
    end
endmodule

// File: rtl/vx_warp_scheduler.sv
// vx_warp_scheduler: round-robin fetch warp selector; define VX_SCHED_BARRIER_EN for barrier blocking.
module vx_warp_scheduler
    import vx_sched_pkg::*;
#(
    parameter int NUM_WARPS = NUM_WARPS_DEF
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           global_stall_i,
    input  logic                           spawn_valid_i,
    input  logic [NUM_WARPS-1:0]           spawn_mask_i,
    input  logic                           term_valid_i,
    input  logic [warp_w(NUM_WARPS)-1:0]   term_warp_i,
    input  logic                           br_issue_valid_i,
    input  logic [warp_w(NUM_WARPS)-1:0]   br_issue_warp_i,
    input  logic                           br_resolve_valid_i,
    input  logic [warp_w(NUM_WARPS)-1:0]   br_resolve_warp_i,
`ifdef VX_SCHED_BARRIER_EN
    input  logic                           bar_valid_i,
    input  logic [warp_w(NUM_WARPS)-1:0]   bar_warp_i,
    input  logic [warp_w(NUM_WARPS):0]     bar_count_i,
`endif
    output logic                           sched_valid_o,
    output logic [warp_w(NUM_WARPS)-1:0]   sched_warp_o,
    output logic [NUM_WARPS-1:0]           active_mask_o,
    output logic                           all_done_o
);
    localparam int WARP_W = warp_w(NUM_WARPS);
    logic [NUM_WARPS-1:0] active_q, active_d, stalled_q, stalled_d, eligible;
    logic [WARP_W-1:0]    last_q, last_d, pick_idx;
    logic                 pick_valid;
`ifdef VX_SCHED_BARRIER_EN
    logic [NUM_WARPS-1:0] blocked_q, blocked_d;
    logic [WARP_W:0]      arrive_q, arrive_d;
    assign eligible = active_q & ~stalled_q & ~blocked_q;
`else
    assign eligible = active_q & ~stalled_q;
`endif
    vx_rr_picker #(.N(NUM_WARPS)) u_pick (
        .req_i   (global_stall_i ? '0 : eligible),
        .last_i  (last_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );
    assign sched_valid_o = pick_valid;
    assign sched_warp_o  = pick_valid ? pick_idx : '0;
    assign active_mask_o = active_q;
    assign all_done_o    = ~|active_q;
    assign last_d        = pick_valid ? pick_idx : last_q;
    always_comb begin
        active_d  = active_q;
        stalled_d = stalled_q;
        if (spawn_valid_i)
            active_d = active_d | spawn_mask_i;
        if (br_resolve_valid_i)
            stalled_d[br_resolve_warp_i] = 1'b0;
        // issue after resolve so a same-warp collision leaves the warp stalled
        if (br_issue_valid_i && active_q[br_issue_warp_i])
            stalled_d[br_issue_warp_i] = 1'b1;
        if (term_valid_i) begin
            active_d[term_warp_i]  = 1'b0;
            stalled_d[term_warp_i] = 1'b0;
        end
    end
`ifdef VX_SCHED_BARRIER_EN
    always_comb begin
        blocked_d = blocked_q;
        arrive_d  = arrive_q;
        if (bar_valid_i) begin
            if (arrive_q + 1'b1 == bar_count_i) begin
                blocked_d = '0;
                arrive_d  = '0;
            end else begin
                blocked_d[bar_warp_i] = 1'b1;
                arrive_d              = arrive_q + 1'b1;
            end
        end
        if (term_valid_i)
            blocked_d[term_warp_i] = 1'b0;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blocked_q <= '0;
            arrive_q  <= '0;
        end else begin
            blocked_q <= blocked_d;
            arrive_q  <= arrive_d;
        end
    end
`endif
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_q  <= NUM_WARPS'(1);
            stalled_q <= '0;
            last_q    <= WARP_W'(NUM_WARPS - 1);
        end else begin
            active_q  <= active_d;
            stalled_q <= stalled_d;
            last_q    <= last_d;
        end
    end
endmodule

// File: tb/tb_vx_warp_scheduler.sv
// tb_vx_warp_scheduler: directed checks of grant order, stalls, spawn/terminate and reset.
module tb_vx_warp_scheduler;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       global_stall, spawn_valid, term_valid, br_issue_valid, br_resolve_valid;
    logic [3:0] spawn_mask;
    logic [1:0] term_warp, br_issue_warp, br_resolve_warp;
    logic       sched_valid, all_done;
    logic [1:0] sched_warp;
    logic [3:0] active_mask;
    int         checks = 0;
    int         failures = 0;
    always #5 clk = ~clk;
    vx_warp_scheduler #(.NUM_WARPS(4)) dut (
        .clk                (clk),
        .reset              (reset),
        .global_stall_i     (global_stall),
        .spawn_valid_i      (spawn_valid),
        .spawn_mask_i       (spawn_mask),
        .term_valid_i       (term_valid),
        .term_warp_i        (term_warp),
        .br_issue_valid_i   (br_issue_valid),
        .br_issue_warp_i    (br_issue_warp),
        .br_resolve_valid_i (br_resolve_valid),
        .br_resolve_warp_i  (br_resolve_warp),
        .sched_valid_o      (sched_valid),
        .sched_warp_o       (sched_warp),
        .active_mask_o      (active_mask),
        .all_done_o         (all_done)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic idle();
        global_stall = 0; spawn_valid = 0; term_valid = 0;
        br_issue_valid = 0; br_resolve_valid = 0;
        spawn_mask = '0; term_warp = '0; br_issue_warp = '0; br_resolve_warp = '0;
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask
    task automatic grant(input string tag, input int w);
        #1;
        check({tag, "_v"}, 32'(sched_valid), 32'd1);
        check(tag, 32'(sched_warp), 32'(w));
        tick();
    endtask
    initial begin
        idle();
        #12;
        check("rst_active", 32'(active_mask), 32'h1);
        check("rst_done", 32'(all_done), 32'd0);
        reset = 1'b0;
        grant("rst_g0", 0);
        grant("rst_g0b", 0);
        spawn_valid = 1; spawn_mask = 4'b1110;
        grant("pre_spawn", 0);
        #1 check("spawn_active", 32'(active_mask), 32'hf);
        grant("rr1", 1);
        grant("rr2", 2);
        grant("rr3", 3);
        grant("rr0", 0);
        grant("rr1b", 1);
        br_issue_valid = 1; br_issue_warp = 2;
        grant("issue2", 2);
        grant("skip_a", 3);
        grant("skip_b", 0);
        br_resolve_valid = 1; br_resolve_warp = 2;
        grant("skip_c", 1);
        grant("resume2", 2);
        grant("resume3", 3);
        br_issue_valid = 1; br_issue_warp = 1;
        br_resolve_valid = 1; br_resolve_warp = 1;
        spawn_valid = 1; spawn_mask = 4'b1000;
        term_valid = 1; term_warp = 3;
        grant("coll", 0);
        #1 check("coll_active", 32'(active_mask), 32'h7);
        grant("stall1_a", 2);
        br_resolve_valid = 1; br_resolve_warp = 1;
        grant("stall1_b", 0);
        grant("rel1", 1);
        global_stall = 1;
        #1;
        check("gstall_v", 32'(sched_valid), 32'd0);
        check("gstall_w", 32'(sched_warp), 32'd0);
        tick();
        grant("after_gstall", 2);
        term_valid = 1; term_warp = 1;
        grant("term1", 0);
        term_valid = 1; term_warp = 2;
        grant("term2", 2);
        term_valid = 1; term_warp = 0;
        grant("term0", 0);
        #1;
        check("done", 32'(all_done), 32'd1);
        check("done_v", 32'(sched_valid), 32'd0);
        check("done_w", 32'(sched_warp), 32'd0);
        check("done_mask", 32'(active_mask), 32'h0);
        tick();
        #1 check("done_hold", 32'(all_done), 32'd1);
        spawn_valid = 1; spawn_mask = 4'b1000;
        br_issue_valid = 1; br_issue_warp = 3;
        tick();
        #1 check("respawn_done", 32'(all_done), 32'd0);
        grant("respawn3", 3);
        spawn_valid = 1; spawn_mask = 4'b1100;
        grant("respawn3b", 3);
        grant("rr2_after", 2);
        #1 reset = 1'b1;
        #1;
        check("arst_mask", 32'(active_mask), 32'h1);
        check("arst_w", 32'(sched_warp), 32'd0);
        check("arst_v", 32'(sched_valid), 32'd1);
        reset = 1'b0;
        tick();
        grant("post_arst", 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
